// File: rtl/bist_seq_controller.sv
// BIST sequencer: walks INIT -> (SHIFT, CAPTURE) x N_PATTERNS -> FINISH -> DONE and drives scan mode and phase flags.
// Optional build macro BIST_SIGCHECK_EN adds the final MISR signature check against GOLDEN_SIG.
module bist_seq_controller #(
  parameter int                   SCAN_LEN    = 8,
  parameter int                   N_PATTERNS  = 1000,
  parameter int                   INIT_CYCLES = 4,
  parameter int                   SIG_WIDTH   = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG  = {SIG_WIDTH{1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bist_start,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 mode,
  output logic                 init,
  output logic                 running,
  output logic                 finish,
  output logic                 bist_end,
  output logic                 pass,
  output logic                 fail
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int PH_MAX = (SCAN_LEN > INIT_CYCLES) ? SCAN_LEN : INIT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int PAT_W  = $clog2(N_PATTERNS) + 1;

  localparam logic [PH_W-1:0]  PH_ZERO   = PH_W'(0);
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]  INIT_LAST = PH_W'(INIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  SCAN_LAST = PH_W'(SCAN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_ZERO  = PAT_W'(0);
  localparam logic [PAT_W-1:0] PAT_ONE   = PAT_W'(1);
  localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(N_PATTERNS - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic               start_q_r;
  logic               rise_s;
  logic               accept_s;
  logic               sig_latch_s;
  logic [PH_W-1:0]    phase_cnt_r;
  logic [PH_W-1:0]    phase_cnt_nxt_s;
  logic [PAT_W-1:0]   pat_cnt_r;
  logic [PAT_W-1:0]   pat_cnt_nxt_s;
  logic [4:0]         flags_nxt_s;
  logic               mode_r;
  logic               init_r;
  logic               running_r;
  logic               finish_r;
  logic               bist_end_r;

  assign rise_s   = bist_start & ~start_q_r;
  assign accept_s = rise_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));

  // Start edge detector; resets high so a start held through reset is not an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q_r <= 1'b1;
    end else begin
      start_q_r <= bist_start;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    next_state_s    = state_r;
    phase_cnt_nxt_s = phase_cnt_r + PH_ONE;
    pat_cnt_nxt_s   = pat_cnt_r;
    sig_latch_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        phase_cnt_nxt_s = PH_ZERO;
        if (accept_s) begin
          next_state_s  = ST_INIT;
          pat_cnt_nxt_s = PAT_ZERO;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (phase_cnt_r == INIT_LAST) begin
          next_state_s    = ST_SHIFT;
          phase_cnt_nxt_s = PH_ZERO;
        end else begin
          next_state_s    = ST_INIT;
        end
      end
      ST_SHIFT: begin
        if (phase_cnt_r == SCAN_LAST) begin
          next_state_s    = ST_CAPTURE;
          phase_cnt_nxt_s = PH_ZERO;
        end else begin
          next_state_s    = ST_SHIFT;
        end
      end
      ST_CAPTURE: begin
        phase_cnt_nxt_s = PH_ZERO;
        if (pat_cnt_r == PAT_LAST) begin
          next_state_s  = ST_FINISH;
        end else begin
          next_state_s  = ST_SHIFT;
          pat_cnt_nxt_s = pat_cnt_r + PAT_ONE;
        end
      end
      ST_FINISH: begin
        if (phase_cnt_r == SCAN_LAST) begin
          next_state_s    = ST_DONE;
          phase_cnt_nxt_s = PH_ZERO;
          sig_latch_s     = 1'b1;
        end else begin
          next_state_s    = ST_FINISH;
        end
      end
      ST_DONE: begin
        phase_cnt_nxt_s = PH_ZERO;
        if (accept_s) begin
          next_state_s  = ST_INIT;
          pat_cnt_nxt_s = PAT_ZERO;
        end else begin
          next_state_s  = ST_DONE;
        end
      end
      default: begin
        next_state_s    = ST_IDLE;
        phase_cnt_nxt_s = PH_ZERO;
        pat_cnt_nxt_s   = PAT_ZERO;
      end
    endcase
  end

  // Flags decoded from the next state so the registered outputs track the state register
  always_comb begin
    flags_nxt_s = 5'b00000;
    case (next_state_s)
      ST_IDLE:    flags_nxt_s = 5'b00000;
      ST_INIT:    flags_nxt_s = 5'b01000;
      ST_SHIFT:   flags_nxt_s = 5'b10100;
      ST_CAPTURE: flags_nxt_s = 5'b00100;
      ST_FINISH:  flags_nxt_s = 5'b10010;
      ST_DONE:    flags_nxt_s = 5'b00001;
      default:    flags_nxt_s = 5'b00000;
    endcase
  end

  // State, counters and registered phase flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= PH_ZERO;
      pat_cnt_r   <= PAT_ZERO;
      mode_r      <= 1'b0;
      init_r      <= 1'b0;
      running_r   <= 1'b0;
      finish_r    <= 1'b0;
      bist_end_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      phase_cnt_r <= phase_cnt_nxt_s;
      pat_cnt_r   <= pat_cnt_nxt_s;
      mode_r      <= flags_nxt_s[4];
      init_r      <= flags_nxt_s[3];
      running_r   <= flags_nxt_s[2];
      finish_r    <= flags_nxt_s[1];
      bist_end_r  <= flags_nxt_s[0];
    end
  end

  assign mode     = mode_r;
  assign init     = init_r;
  assign running  = running_r;
  assign finish   = finish_r;
  assign bist_end = bist_end_r;

`ifdef BIST_SIGCHECK_EN
  logic pass_r;
  logic fail_r;

  function automatic logic sig_match(input logic [SIG_WIDTH-1:0] sig,
                                     input logic [SIG_WIDTH-1:0] golden);
    return (sig == golden);
  endfunction

  // Verdict latched on FINISH->DONE, cleared on every accepted start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_r <= 1'b0;
      fail_r <= 1'b0;
    end else if (accept_s) begin
      pass_r <= 1'b0;
      fail_r <= 1'b0;
    end else if (sig_latch_s) begin
      pass_r <= sig_match(signature, GOLDEN_SIG);
      fail_r <= ~sig_match(signature, GOLDEN_SIG);
    end else begin
      pass_r <= pass_r;
      fail_r <= fail_r;
    end
  end

  assign pass = pass_r;
  assign fail = fail_r;
`else
  logic unused_sig_s;

  assign unused_sig_s = ^{signature, sig_latch_s};
  assign pass         = 1'b0;
  assign fail         = 1'b0;
`endif

endmodule

// File: tb/tb_bist_seq_controller.sv
// Randomized self-checking bench for bist_seq_controller against a run-offset reference model.
`timescale 1ns/1ps
module tb_bist_seq_controller;

  localparam int          SCAN_LEN    = 4;
  localparam int          N_PATTERNS  = 3;
  localparam int          INIT_CYCLES = 2;
  localparam int          SIG_WIDTH   = 16;
  localparam logic [15:0] GOLDEN      = 16'h0000;
  localparam int          T_RUN       = INIT_CYCLES + N_PATTERNS * (SCAN_LEN + 1) + SCAN_LEN;
  localparam int          PAT_END     = INIT_CYCLES + N_PATTERNS * (SCAN_LEN + 1);

  logic        clock;
  logic        reset;
  logic        bist_start;
  logic [15:0] signature;
  logic        mode, init, running, finish, bist_end, pass, fail;

  int n_vec;
  int n_miss;

  // reference model: run offset since the accepted start edge
  logic m_prev;
  logic m_active;
  logic m_done;
  logic m_pass;
  logic m_fail;
  int   m_t;

  bist_seq_controller #(
    .SCAN_LEN   (SCAN_LEN),
    .N_PATTERNS (N_PATTERNS),
    .INIT_CYCLES(INIT_CYCLES),
    .SIG_WIDTH  (SIG_WIDTH),
    .GOLDEN_SIG (GOLDEN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bist_start(bist_start),
    .signature (signature),
    .mode      (mode),
    .init      (init),
    .running   (running),
    .finish    (finish),
    .bist_end  (bist_end),
    .pass      (pass),
    .fail      (fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_prev   <= 1'b1;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pass   <= 1'b0;
      m_fail   <= 1'b0;
      m_t      <= 0;
    end else begin
      m_prev <= bist_start;
      if (bist_start && !m_prev && !m_active) begin
        m_active <= 1'b1;
        m_done   <= 1'b0;
        m_pass   <= 1'b0;
        m_fail   <= 1'b0;
        m_t      <= 0;
      end else if (m_active) begin
        m_t <= m_t + 1;
        if (m_t + 1 == T_RUN) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
`ifdef BIST_SIGCHECK_EN
          m_pass   <= (signature == GOLDEN);
          m_fail   <= (signature != GOLDEN);
`else
          m_pass   <= 1'b0;
          m_fail   <= 1'b0;
`endif
        end
      end
    end
  end

  // {mode, init, running, finish, bist_end, pass, fail}
  function automatic logic [6:0] exp_vec();
    int r;
    if (m_active) begin
      if (m_t < INIT_CYCLES) return 7'b0100000;
      if (m_t < PAT_END) begin
        r = (m_t - INIT_CYCLES) % (SCAN_LEN + 1);
        return (r < SCAN_LEN) ? 7'b1010000 : 7'b0010000;
      end
      return 7'b1001000;
    end
    if (m_done) return {5'b00001, m_pass, m_fail};
    return 7'b0000000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("outputs", {25'd0, mode, init, running, finish, bist_end, pass, fail}, {25'd0, exp_vec()});
    check_val("phase_onehot", 32'($countones({init, running, finish, bist_end})),
              (m_active || m_done) ? 32'd1 : 32'd0);
  endtask

  task automatic tick(input logic st);
    @(negedge clock);
    check_outputs();
    bist_start = st;
    case ($urandom_range(0, 2))
      0:       signature = GOLDEN;
      1:       signature = 16'h0001;
      default: signature = 16'($urandom);
    endcase
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b0;
    bist_start = 1'b1;
    signature  = 16'h0000;

    // start held high through reset release must not launch a run
    repeat (3) tick(1'b1);
    #3 reset = 1'b1;
    repeat (10) tick(1'b1);
    tick(1'b0);

    // normal run from a single-cycle pulse
    tick(1'b1);
    repeat (30) tick(1'b0);

    // second pulse during pattern 1 shift is ignored
    tick(1'b1);
    repeat (8) tick(1'b0);
    tick(1'b1);
    repeat (30) tick(1'b0);

    // restart from DONE
    tick(1'b1);
    repeat (30) tick(1'b0);

    // asynchronous reset during CAPTURE of pattern 0
    tick(1'b1);
    repeat (7) tick(1'b0);
    #2 reset = 1'b0;
    #1 check_outputs();
    repeat (300) tick(1'b0);
    #2 reset = 1'b1;
    tick(1'b1);
    repeat (30) tick(1'b0);

    // randomized pulses, widths and occasional asynchronous resets
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 25)) tick(1'b0);
      repeat ($urandom_range(1, 4)) tick(1'b1);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clock);
        #3 reset = 1'b0;
        #1 check_outputs();
        repeat (2) tick(1'b0);
        #4 reset = 1'b1;
      end
    end
    repeat (30) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
